// File: rtl/fft_output_reorder_if.sv
// fft_output_reorder_if: sample stream in from the FFT core and natural-order stream out
interface fft_output_reorder_if #(parameter int DW = 16, parameter int LOG2_NMAX = 11);
  logic [1:0] np;
  logic valid_in;
  logic sop_in;
  logic [DW-1:0] x_re;
  logic [DW-1:0] x_im;
  logic valid_out;
  logic sop_out;
  logic eop_out;
  logic [LOG2_NMAX-1:0] idx_out;
  logic [DW-1:0] y_re;
  logic [DW-1:0] y_im;
  logic ovf;
  modport master (output np, valid_in, sop_in, x_re, x_im,
                  input valid_out, sop_out, eop_out, idx_out, y_re, y_im, ovf);
  modport slave (input np, valid_in, sop_in, x_re, x_im,
                 output valid_out, sop_out, eop_out, idx_out, y_re, y_im, ovf);
endinterface

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong buffer turning bit-reversed FFT frames into natural-order bursts
module fft_output_reorder #(
  parameter int DW = 16,
  parameter int LOG2_NMAX = 11
) (
  input logic clk,
  input logic rst,
  fft_output_reorder_if.slave bus
);
  localparam int AW = LOG2_NMAX;
  localparam int SH = LOG2_NMAX - 8;
  localparam logic [1:0] EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, READING = 2'd3;
  localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, DROP = 2'd2;

  function automatic logic [AW-1:0] last_of(input logic [1:0] p);
    return {AW{1'b1}} >> (SH - int'(p));
  endfunction

  function automatic logic [AW-1:0] brev(input logic [AW-1:0] k, input logic [1:0] p);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
    return r >> (SH - int'(p));
  endfunction

  logic [1:0][1:0] st, st_n, bnp;
  logic [1:0] wst, wnp, wnp_c, free;
  logic wb, wbank, nb, old, pick, start, rd_go, rd_act, rd_end, rb, cb;
  logic sop_acc, claim, wr_now, wlast, ovf_c;
  logic [AW-1:0] k, wk, ra, caddr, p1_idx;
  logic p1_v, p1_sop, p1_eop;
  logic [2*DW-1:0] mem [0:2**(AW+1)-1];
  logic [2*DW-1:0] rdata;

  always_comb begin
    pick = (st[0] == FULL && st[1] == FULL) ? old : (st[1] == FULL);
    start = !rd_act && (st[0] == FULL || st[1] == FULL);
    rd_go = rd_act || start;
    cb = rd_act ? rb : pick;
    caddr = rd_act ? ra : '0;
    rd_end = rd_go && caddr == last_of(bnp[cb]);
    free[0] = st[0] == EMPTY || (rd_end && !cb);
    free[1] = st[1] == EMPTY || (rd_end && cb);
    sop_acc = bus.valid_in && bus.sop_in;
    claim = sop_acc && wst != WR;
    nb = !free[0];
    wr_now = (claim && |free) || (wst == WR && bus.valid_in);
    wbank = claim ? nb : wb;
    wnp_c = sop_acc ? bus.np : wnp;
    wk = sop_acc ? '0 : k;
    wlast = wst == WR && bus.valid_in && !sop_acc && k == last_of(wnp);
    ovf_c = sop_acc && (wst == WR || !(|free));
    st_n = st;
    for (int i = 0; i < 2; i++)
      st_n[i] = (wlast && wb == 1'(i)) ? FULL :
                (claim && |free && nb == 1'(i)) ? FILLING :
                (rd_go && cb == 1'(i)) ? (rd_end ? EMPTY : READING) : st[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
      bnp <= '0;
      wst <= IDLE;
      wb <= 1'b0;
      wnp <= '0;
      k <= '0;
      old <= 1'b0;
      rd_act <= 1'b0;
      rb <= 1'b0;
      ra <= '0;
      p1_v <= 1'b0;
      p1_sop <= 1'b0;
      p1_eop <= 1'b0;
      p1_idx <= '0;
      bus.valid_out <= 1'b0;
      bus.sop_out <= 1'b0;
      bus.eop_out <= 1'b0;
      bus.idx_out <= '0;
      bus.y_re <= '0;
      bus.y_im <= '0;
      bus.ovf <= 1'b0;
    end else begin
      st <= st_n;
      bus.ovf <= ovf_c;
      wst <= claim ? (|free ? WR : DROP) : wlast ? IDLE : wst;
      if (claim && |free) wb <= nb;
      if (wr_now) k <= wk + 1'b1;
      if (wr_now && sop_acc) begin
        wnp <= bus.np;
        bnp[wbank] <= bus.np;
      end
      if (wlast) old <= (st[~wb] == FULL) ? ~wb : wb;
      rd_act <= rd_go && !rd_end;
      if (rd_go) begin
        rb <= cb;
        ra <= caddr + 1'b1;
        p1_idx <= caddr;
      end
      p1_v <= rd_go;
      p1_sop <= rd_go && caddr == '0;
      p1_eop <= rd_end;
      bus.valid_out <= p1_v;
      bus.sop_out <= p1_sop;
      bus.eop_out <= p1_eop;
      if (p1_v) begin
        bus.idx_out <= p1_idx;
        bus.y_re <= rdata[2*DW-1:DW];
        bus.y_im <= rdata[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_now) mem[{wbank, brev(wk, wnp_c)}] <= {bus.x_re, bus.x_im};
    if (rd_go) rdata <= mem[{cb, caddr}];
  end
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: directed frames with tagged bit-reversed payloads checked for natural order
module tb_fft_output_reorder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_output_reorder_if #(.DW(16), .LOG2_NMAX(11)) bus();
  fft_output_reorder #(.DW(16), .LOG2_NMAX(11)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [10:0] idx;
    logic sop;
    logic eop;
    int cyc;
  } smp_t;

  smp_t q[$];
  int cyc = 0;
  int n_ovf = 0;
  int last_in = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (bus.valid_out === 1'b1)
        q.push_back(smp_t'{bus.y_re, bus.y_im, bus.idx_out, bus.sop_out, bus.eop_out, cyc});
      if (bus.ovf === 1'b1) n_ovf++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] brev(input int j, input int l);
    logic [10:0] r = '0;
    for (int i = 0; i < l; i++) r[l-1-i] = j[i];
    return r;
  endfunction

  task automatic send(input logic [1:0] p, input logic [3:0] tag, input bit gaps, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      if (gaps && j % 3 == 2) begin
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.sop_in = 1'b0;
      end
      @(negedge clk);
      bus.np = p;
      bus.valid_in = 1'b1;
      bus.sop_in = (j == 0);
      bus.x_re = {tag, 1'b0, brev(j, 8 + int'(p))};
      bus.x_im = ~bus.x_re;
      last_in = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.sop_in = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int n);
    int b = 0;
    while (q.size() < n && b < 20000) begin
      idle(1);
      b++;
    end
    idle(40);
    chk({tag, "_count"}, q.size(), n);
  endtask

  task automatic burst(input string tag, input int s, input int n, input logic [3:0] t);
    int bad = 0;
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      e = {t, 1'b0, 11'(i)};
      if (s + i >= q.size()) bad++;
      else if (q[s+i].re !== e || q[s+i].im !== ~e || q[s+i].idx !== 11'(i) ||
               q[s+i].sop !== (i == 0) || q[s+i].eop !== (i == n - 1) ||
               q[s+i].cyc !== q[s].cyc + i) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int n;
    bus.np = 2'd0;
    bus.valid_in = 1'b0;
    bus.sop_in = 1'b0;
    bus.x_re = '0;
    bus.x_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_sop", bus.sop_out, 0);
    chk("rst_eop", bus.eop_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_idx", bus.idx_out, 0);
    chk("rst_re", bus.y_re, 0);
    chk("rst_im", bus.y_im, 0);
    rst = 1'b0;
    idle(2);

    q.delete();
    n_ovf = 0;
    send(2'd0, 4'd1, 1'b0, 256);
    drain("t1", 256);
    burst("t1_order", 0, 256, 4'd1);
    // last sample captured at edge E, first valid seen after edge E+2
    chk("t1_latency", q.size() > 0 ? q[0].cyc - last_in : -1, 3);
    chk("t1_ovf", n_ovf, 0);

    q.delete();
    n_ovf = 0;
    send(2'd3, 4'd2, 1'b0, 2048);
    send(2'd3, 4'd3, 1'b0, 2048);
    send(2'd3, 4'd4, 1'b0, 2048);
    drain("t2", 6144);
    burst("t2_f0", 0, 2048, 4'd2);
    burst("t2_f1", 2048, 2048, 4'd3);
    burst("t2_f2", 4096, 2048, 4'd4);
    chk("t2_span", q.size() == 6144 ? q[6143].cyc - q[0].cyc : -1, 6143);
    chk("t2_ovf", n_ovf, 0);

    q.delete();
    n_ovf = 0;
    send(2'd1, 4'd5, 1'b1, 512);
    drain("t3", 512);
    burst("t3_order", 0, 512, 4'd5);
    chk("t3_ovf", n_ovf, 0);

    q.delete();
    n_ovf = 0;
    send(2'd2, 4'd6, 1'b0, 600);
    send(2'd2, 4'd7, 1'b0, 1024);
    drain("t4", 1024);
    burst("t4_order", 0, 1024, 4'd7);
    chk("t4_ovf", n_ovf, 1);

    q.delete();
    n_ovf = 0;
    send(2'd3, 4'd8, 1'b0, 2048);
    send(2'd0, 4'd9, 1'b0, 256);
    send(2'd0, 4'd10, 1'b0, 256);
    drain("t5", 2304);
    burst("t5_f0", 0, 2048, 4'd8);
    burst("t5_f1", 2048, 256, 4'd9);
    chk("t5_gap", q.size() > 2048 ? q[2048].cyc - q[2047].cyc : -1, 1);
    chk("t5_ovf", n_ovf, 1);

    q.delete();
    send(2'd0, 4'd11, 1'b0, 256);
    send(2'd0, 4'd12, 1'b0, 100);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.sop_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid", bus.valid_out, 0);
    chk("t6_idx", bus.idx_out, 0);
    chk("t6_re", bus.y_re, 0);
    n = q.size();
    chk("t6_midburst", n > 0 && n < 256, 1);
    idle(400);
    chk("t6_quiet", q.size(), n);
    q.delete();
    n_ovf = 0;
    send(2'd0, 4'd13, 1'b0, 256);
    drain("t6_fresh", 256);
    burst("t6_order", 0, 256, 4'd13);
    chk("t6_ovf", n_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Natural-order output buffer for the multipoint FFT core. It accepts the core's result stream, which arrives in bit-reversed index order, one frame of N = 256/512/1024/2048 complex samples at a time. It stores each frame in a ping-pong RAM and replays it in natural order, 0..N-1, as a gap-free burst. It sits directly downstream of `fft_multipoint` and connects to its `valid_out`, `sop_out`, `y_re` and `y_im`.

## Interface
- `DW`, 16: real/imag sample width, two's complement, passed through unmodified.
- `LOG2_NMAX`, 11: log2 of the largest frame; each bank holds 2^LOG2_NMAX words of 2*DW bits.
- `clk` in, 1: the single clock; all logic is on its rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `np` in, 2: frame size, N = 256 << np (00→256, 11→2048). Latched at the accepted `sop_in`.
- `valid_in` in, 1: input sample qualifier.
- `sop_in` in, 1: first sample of a frame; honoured only when `valid_in` is high.
- `x_re`, `x_im` in, DW each: input sample.
- `valid_out` out, 1: output sample valid.
- `sop_out` out, 1: output index 0.
- `eop_out` out, 1: output index N-1.
- `idx_out` out, LOG2_NMAX: natural-order index of the current output sample.
- `y_re`, `y_im` out, DW each: output sample.
- `ovf` out, 1: one-cycle pulse when an input frame is dropped or truncated.

## Operation
- **Bank states.** There are two banks, A and B. Each bank is in one of EMPTY, FILLING, FULL or READING.
- **Writer.**
  - Writer cycle: `valid_in`=1 in the WR state.
  - An accepted `sop_in` in IDLE claims an EMPTY bank (A has priority), latches `np` as L = 8 + np, clears the count k and enters WR.
  - On each writer cycle, store {x_re, x_im} at address bitrev_L(k): the L LSBs of k, reversed. Then increment k.
  - At k = N-1 the bank becomes FULL and the writer returns to IDLE.
  - `valid_in`=0 stalls the writer; k holds.
  - `valid_in` without `sop_in` in IDLE is ignored.
- **Mid-frame `sop_in`** while in WR:
  - `ovf` pulses.
  - The partial frame is discarded: k is cleared, `np` is relatched, and the current sample is written as k=0 of a new frame in the same bank.
- **Overflow.** An accepted `sop_in` in IDLE with no EMPTY bank:
  - `ovf` pulses.
  - The writer enters DROP and ignores samples until the next `sop_in`, which is re-evaluated like an IDLE `sop_in`.
- **Reader.**
  - When no bank is READING and a bank is FULL, the reader starts on that bank at the next edge. If both banks are FULL, the one filled first goes first.
  - It reads addresses 0..N-1 of that frame's latched N, one per cycle, with no stalls.
  - After address N-1 is issued, the bank becomes EMPTY.
- **Output format.**
  - The RAM read is synchronous, and all outputs are registered.
  - `idx_out` = natural index.
  - `sop_out` is asserted at index 0 and `eop_out` at index N-1, each with `valid_out`=1.
- **Data handling.**
  - No arithmetic; data is bit-exact.
  - `y_re`/`y_im` hold their last value when `valid_out`=0.
- **Reset.** Forces every bank to EMPTY and the writer to IDLE, and aborts the reader.
  - On the next cycle `valid_out`, `sop_out`, `eop_out` and `ovf` are 0, and `idx_out`, `y_re` and `y_im` are 0.
  - Frames already buffered are lost.

## Timing
- **Latency.** The last input sample is captured at edge E, and its bank goes FULL at E.
  - If the reader is idle, the read of address 0 is issued at E+1.
  - `valid_out`/`sop_out` go high after edge E+2.
  - The burst lasts exactly N cycles.
- **Back-to-back output.** If the other bank is FULL when the last read address is issued, its address 0 is issued on the next edge. The output then shows `eop_out` followed immediately by `sop_out`, with zero gap cycles.
- **Simultaneous events.**
  - A bank leaving READING→EMPTY in the same cycle as an IDLE `sop_in`: the `sop_in` claims that bank, and no `ovf` is raised.
  - Bank handoff for a new write therefore takes 0 extra cycles.
- **Throughput.** At 1 sample/cycle input with a constant N, the block never overflows.
  - A 2048-point frame followed by two back-to-back 256-point frames overflows on the second 256-point frame.
- **Ready timing.** `ovf` is registered: it is asserted the cycle after the offending `sop_in` edge.

## Test plan
- **256-point frame.** Set np=00 and send a 256-point frame where input position j carries x_re = bitrev_8(j), x_im = ~bitrev_8(j). Required: `y_re` = 0,1,…,255 in order; `y_im` = ~`y_re`; `idx_out` = `y_re`; `sop_out` at 0, `eop_out` at 255; first `valid_out` 2 cycles after the last input; no `ovf`.
- **2048-point back-to-back.** Set np=11 and send three 2048-point frames back-to-back with `valid_in` held high. Required: 6144 consecutive `valid_out` cycles, each frame in natural order, `eop_out`→`sop_out` adjacent, no `ovf`.
- **Input gaps.** Send a 512-point frame with `valid_in` deasserted on every 3rd cycle. Required: output identical to the gap-free case, with one N=512 contiguous burst.
- **Mid-frame restart.** Send a 1024-point frame and assert `sop_in` at k=600. Required: one `ovf` pulse; the first 600 samples are never output; the second frame is output intact as 1024 samples.
- **Overflow on size change.** Send a 2048-point frame, then two 256-point frames back-to-back. Required: `ovf` on the second 256-point `sop_in`. The output is the 2048-point frame followed by the first 256-point frame only.
- **Reset mid-operation.** Assert `rst` for 1 cycle during a READING burst while the other bank is FILLING. Required: `valid_out`=0 from the next cycle; no further output until a fresh frame is sent, which is then output correctly.
